fan_result_collector: RTL and testbench
=======================================

# fan_result_collector

Drain end of the forwarding-adder network (FAN) for the unstructured sparse path. It captures one NUM_IN-lane vector of FAN output lines and discards empty lanes. Each occupied lane is emitted as one result beat, in ascending lane order, on a valid/ready stream toward the row accumulator. It is the consumer of the line format driven by the FAN adder stages: {ctrl, row, data}, with ctrl in the MSBs.

## Interface
- N_STACK, 4, data words per line
- DW_DATA, 32, bits per data word
- DW_ROW, 4, row-index width
- DW_CTRL, 4, control-field width
- DW_LINE, N_STACK*DW_DATA+DW_ROW+DW_CTRL, line width
- NUM_IN, 8, lanes per vector (power of two)
- DW_LANE, log2(NUM_IN), lane-index width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input vector present
- in_ready  out  1  collector accepts the vector this cycle
- in  in  NUM_IN*DW_LINE  lane i at [i*DW_LINE +: DW_LINE]
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts the beat
- out_data  out  N_STACK*DW_DATA  line data field
- out_row  out  DW_ROW  line row field
- out_lane  out  DW_LANE  source lane index
- out_complete  out  1  reduction finished for this row segment
- out_last  out  1  final beat of the current vector
- vec_cnt  out  16  vectors fully drained since reset (wraps)

## Operation
- Control field ctrl = line[DW_LINE-1 -: DW_CTRL]:
  - ctrl[3] = ADD (line still participates in reduction).
  - ctrl[2] = KEEP (line carries retained data).
  - ctrl[1:0] = segment-end flags.
- Lane occupancy: a lane is occupied iff ctrl[3] | ctrl[2]. Lanes with both bits 0 are dropped and never emitted.
- out_complete = (ctrl[3]==0) && (ctrl[2]==1) && (ctrl[1:0]==2'b11); i.e. ctrl==4'b0111. All other occupied lines are partial sums with out_complete=0.
- Storage: one vector buffer holding NUM_IN lines plus a NUM_IN-bit pending mask.
- Capture: on in_valid && in_ready:
  - all lines are stored;
  - pending is set to the occupancy mask.
- Emission:
  - out_valid = |pending.
  - The selected lane is the lowest set bit of pending.
  - out_data, out_row and out_lane come from the selected lane.
  - out_last = exactly one pending bit set.
- Beat transfer: on out_valid && out_ready, the selected pending bit clears.
- vec_cnt increments by 1 when either of these occurs:
  - a beat with out_last is transferred;
  - an all-empty vector is accepted.
  At most one increment per cycle. Wraps at 2^16.
- in_ready = (pending==0) || (out_valid && out_ready && out_last), so vectors can be accepted back-to-back.
- Simultaneous last-beat transfer and new capture: pending loads the new occupancy mask. The new mask overrides the clear.
- All-empty vector: accepted normally. pending stays 0, no beat is produced, vec_cnt still increments.
- Partial and complete lines are emitted alike. The collector performs no arithmetic and never modifies data or row.
- When out_valid=0: out_data, out_row, out_lane, out_complete and out_last are all 0.

## Timing
- Reset values:
  - pending=0, buffer=0, vec_cnt=0;
  - out_valid=0, in_ready=1;
  - all output data fields 0.
- rst asserted mid-drain: pending beats are discarded and the next cycle shows the reset state. An in_valid present during rst is not captured.
- Latency: vector accepted at edge t gives its first beat valid in cycle t+1. The output is combinational from registered state, with no input-to-output combinational path.
- A vector with k occupied lanes drains in k cycles when out_ready is held high.
- Sustained throughput is one beat per cycle. A new vector can be accepted in the same cycle as the previous vector's last beat.
- Back-pressure: while out_valid && !out_ready, every output holds stable and in_ready=0 (unless pending is already 0).
- in is sampled only on the accepting edge. Later changes on in have no effect.

## Test plan
- Reset and idle: rst for 2 cycles, then in_valid=0 -> out_valid=0, in_ready=1, vec_cnt=0, all out fields 0.
- Sparse vector: lane 3 = {4'b0111, row 5, data 0x1}, lane 6 = {4'b1010, row 5, data 0x2}, other lanes 0; out_ready=1 -> exactly two beats:
  - cycle t+1: lane 3, complete=1, last=0;
  - cycle t+2: lane 6, complete=0, last=1.
  Then vec_cnt=1.
- Back-pressure: all 8 lanes carry ctrl 4'b0100, out_ready toggles 1,0,0,1,... -> 8 beats in lanes 0..7 with no loss or duplication, outputs stable while stalled, in_ready=0 until the last beat transfers.
- Back-to-back: two vectors, 1 occupied lane each, in_valid held high -> the second vector is accepted in the cycle the first vector's beat transfers, giving one beat per cycle and vec_cnt=2 after 2 beats.
- Empty vector: all lanes ctrl=4'b0000 -> accepted in 1 cycle, no beat, vec_cnt increments.
- Reset mid-drain: 4 lanes pending, assert rst after the first beat -> no further beats, vec_cnt=0, in_ready=1 the cycle after rst.

Source files
------------

// File: rtl/fan_result_collector_if.sv
// Stream interface for the FAN result collector: one NUM_IN-lane input vector
// on a valid/ready handshake, per-lane result beats on a second valid/ready stream.
interface fan_result_collector_if #(
  parameter int unsigned N_STACK = 4,
  parameter int unsigned DW_DATA = 32,
  parameter int unsigned DW_ROW  = 4,
  parameter int unsigned DW_CTRL = 4,
  parameter int unsigned NUM_IN  = 8
) ();
  localparam int unsigned DW_LINE = N_STACK * DW_DATA + DW_ROW + DW_CTRL;
  localparam int unsigned DW_LANE = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_IN*DW_LINE-1:0]    in;
  logic                         out_valid;
  logic                         out_ready;
  logic [N_STACK*DW_DATA-1:0]   out_data;
  logic [DW_ROW-1:0]            out_row;
  logic [DW_LANE-1:0]           out_lane;
  logic                         out_complete;
  logic                         out_last;
  logic [15:0]                  vec_cnt;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_lane,
           out_complete, out_last, vec_cnt
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out_data, out_row, out_lane,
           out_complete, out_last, vec_cnt
  );
endinterface

// File: rtl/fan_result_collector.sv
// Captures one vector of FAN output lines and emits each occupied lane as a
// result beat in ascending lane order; empty lanes are dropped.
module fan_result_collector #(
  parameter int unsigned N_STACK = 4,
  parameter int unsigned DW_DATA = 32,
  parameter int unsigned DW_ROW  = 4,
  parameter int unsigned DW_CTRL = 4,
  parameter int unsigned NUM_IN  = 8
) (
  input logic                  clk,
  input logic                  rst,
  fan_result_collector_if.slave bus
);
  localparam int unsigned DW_DFLD = N_STACK * DW_DATA;
  localparam int unsigned DW_LINE = DW_DFLD + DW_ROW + DW_CTRL;
  localparam int unsigned DW_LANE = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [DW_LINE-1:0] line_q [NUM_IN];
  logic [NUM_IN-1:0]  pending_q;
  logic [15:0]        vec_cnt_q;

  logic [NUM_IN-1:0]  occ_c;
  logic [DW_LANE-1:0] sel_c;
  logic [DW_LINE-1:0] sel_line_c;
  logic [DW_CTRL-1:0] sel_ctrl_c;
  logic               out_valid_c;
  logic               last_c;
  logic               xfer_c;
  logic               in_ready_c;
  logic               accept_c;

  // Occupancy of the incoming vector: ADD or KEEP set.
  always_comb begin
    logic [DW_CTRL-1:0] lane_ctrl;
    occ_c     = '0;
    lane_ctrl = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      lane_ctrl = bus.in[i*DW_LINE + DW_LINE - 1 -: DW_CTRL];
      occ_c[i]  = lane_ctrl[DW_CTRL-1] | lane_ctrl[DW_CTRL-2];
    end
  end

  // Lowest pending lane wins.
  always_comb begin
    sel_c = '0;
    for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_c = DW_LANE'(i);
    end
  end

  always_comb begin
    sel_line_c  = line_q[sel_c];
    sel_ctrl_c  = sel_line_c[DW_LINE-1 -: DW_CTRL];
    out_valid_c = |pending_q;
    last_c      = out_valid_c && ((pending_q & (pending_q - NUM_IN'(1))) == '0);
    xfer_c      = out_valid_c && bus.out_ready;
    in_ready_c  = (pending_q == '0) || (xfer_c && last_c);
    accept_c    = bus.in_valid && in_ready_c;
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_data     = out_valid_c ? sel_line_c[DW_DFLD-1:0] : '0;
  assign bus.out_row      = out_valid_c ? sel_line_c[DW_DFLD +: DW_ROW] : '0;
  assign bus.out_lane     = out_valid_c ? sel_c : '0;
  assign bus.out_complete = out_valid_c && (sel_ctrl_c == DW_CTRL'(4'b0111));
  assign bus.out_last     = last_c;
  assign bus.vec_cnt      = vec_cnt_q;

  // A new capture overrides the clear of the final pending bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      vec_cnt_q <= '0;
      for (int i = 0; i < int'(NUM_IN); i++) line_q[i] <= '0;
    end else begin
      if (accept_c) begin
        for (int i = 0; i < int'(NUM_IN); i++) line_q[i] <= bus.in[i*DW_LINE +: DW_LINE];
        pending_q <= occ_c;
      end else if (xfer_c) begin
        pending_q[sel_c] <= 1'b0;
      end
      if ((xfer_c && last_c) || (accept_c && (occ_c == '0))) vec_cnt_q <= vec_cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_fan_result_collector.sv
// Randomized and directed bench for fan_result_collector against a queue-of-beats
// reference model.
module tb_fan_result_collector;
  localparam int unsigned N_STACK = 4;
  localparam int unsigned DW_DATA = 32;
  localparam int unsigned DW_ROW  = 4;
  localparam int unsigned DW_CTRL = 4;
  localparam int unsigned NUM_IN  = 8;
  localparam int unsigned DW_DFLD = N_STACK * DW_DATA;
  localparam int unsigned DW_LINE = DW_DFLD + DW_ROW + DW_CTRL;
  localparam int unsigned DW_VEC  = NUM_IN * DW_LINE;

  typedef struct {
    logic [DW_DFLD-1:0] data;
    logic [DW_ROW-1:0]  row;
    logic [2:0]         lane;
    logic               complete;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  beat_t exp_q [$];
  logic [15:0] exp_cnt = 16'd0;

  fan_result_collector_if #(
    .N_STACK(N_STACK), .DW_DATA(DW_DATA), .DW_ROW(DW_ROW),
    .DW_CTRL(DW_CTRL), .NUM_IN(NUM_IN)
  ) bus ();

  fan_result_collector #(
    .N_STACK(N_STACK), .DW_DATA(DW_DATA), .DW_ROW(DW_ROW),
    .DW_CTRL(DW_CTRL), .NUM_IN(NUM_IN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW_LINE-1:0] got, input logic [DW_LINE-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW_LINE-1:0] mk_line(input logic [3:0] ctrl, input logic [3:0] row,
                                                 input logic [DW_DFLD-1:0] data);
    return {ctrl, row, data};
  endfunction

  function automatic logic [DW_VEC-1:0] rand_vec(input int density);
    logic [DW_VEC-1:0] v;
    logic [DW_DFLD-1:0] d;
    logic [3:0] c;
    v = '0;
    for (int l = 0; l < int'(NUM_IN); l++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      c = ($urandom_range(0, 99) < density) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if ($urandom_range(0, 7) == 0) c = 4'b0111;
      v[l*DW_LINE +: DW_LINE] = mk_line(c, 4'($urandom_range(0, 15)), d);
    end
    return v;
  endfunction

  // One cycle: drive, check outputs against model, advance model across the edge.
  task automatic step(input logic r, input logic v, input logic [DW_VEC-1:0] vec, input logic ordy);
    beat_t b;
    logic  ev, pop, acc, inc;
    logic [3:0] c;
    logic [DW_LINE-1:0] ln;
    @(negedge clk);
    rst = r;
    bus.in_valid  = v;
    bus.in        = vec;
    bus.out_ready = ordy;
    #1;
    ev = (exp_q.size() > 0);
    check("out_valid", DW_LINE'(bus.out_valid), DW_LINE'(ev));
    check("in_ready", DW_LINE'(bus.in_ready),
          DW_LINE'((exp_q.size() == 0) || (exp_q.size() == 1 && ordy)));
    check("vec_cnt", DW_LINE'(bus.vec_cnt), DW_LINE'(exp_cnt));
    if (ev) begin
      b = exp_q[0];
      check("out_data", DW_LINE'(bus.out_data), DW_LINE'(b.data));
      check("out_row", DW_LINE'(bus.out_row), DW_LINE'(b.row));
      check("out_lane", DW_LINE'(bus.out_lane), DW_LINE'(b.lane));
      check("out_complete", DW_LINE'(bus.out_complete), DW_LINE'(b.complete));
      check("out_last", DW_LINE'(bus.out_last), DW_LINE'(exp_q.size() == 1));
    end else begin
      check("idle_fields", DW_LINE'({bus.out_data, bus.out_row, bus.out_lane,
                                     bus.out_complete, bus.out_last}), '0);
    end
    if (r) begin
      exp_q.delete();
      exp_cnt = 16'd0;
    end else begin
      inc = 1'b0;
      pop = ev && ordy;
      acc = v && ((exp_q.size() == 0) || (exp_q.size() == 1 && pop));
      if (pop) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) inc = 1'b1;
      end
      if (acc) begin
        int n_occ;
        n_occ = 0;
        for (int l = 0; l < int'(NUM_IN); l++) begin
          ln = vec[l*DW_LINE +: DW_LINE];
          c  = ln[DW_LINE-1 -: 4];
          if (c[3] || c[2]) begin
            b.data     = ln[DW_DFLD-1:0];
            b.row      = ln[DW_DFLD +: DW_ROW];
            b.lane     = 3'(l);
            b.complete = (c == 4'b0111);
            exp_q.push_back(b);
            n_occ++;
          end
        end
        if (n_occ == 0) inc = 1'b1;
      end
      if (inc) exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  initial begin
    logic [DW_VEC-1:0] v;
    logic [DW_VEC-1:0] w;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset and idle
    step(0, 0, '0, 0);
    step(0, 0, '0, 1);

    // Sparse vector: lanes 3 and 6
    v = '0;
    v[3*DW_LINE +: DW_LINE] = mk_line(4'b0111, 4'd5, DW_DFLD'(1));
    v[6*DW_LINE +: DW_LINE] = mk_line(4'b1010, 4'd5, DW_DFLD'(2));
    step(0, 1, v, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // Back-pressure on a fully occupied vector; a queued one-lane vector waits
    v = '0;
    for (int l = 0; l < int'(NUM_IN); l++)
      v[l*DW_LINE +: DW_LINE] = mk_line(4'b0100, 4'(l), DW_DFLD'(32'hA0 + l));
    w = '0;
    w[2*DW_LINE +: DW_LINE] = mk_line(4'b1000, 4'd9, DW_DFLD'(32'hBEEF));
    step(0, 1, v, 1);
    for (int k = 0; k < 20; k++) step(0, 1, w, pat[k % 4]);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // Back-to-back single-lane vectors
    v = '0;
    v[1*DW_LINE +: DW_LINE] = mk_line(4'b0111, 4'd3, DW_DFLD'(32'h11));
    w = '0;
    w[7*DW_LINE +: DW_LINE] = mk_line(4'b1100, 4'd4, DW_DFLD'(32'h22));
    step(0, 1, v, 1);
    step(0, 1, w, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // All-empty vector, including lanes with only segment flags set
    v = '0;
    v[0*DW_LINE +: DW_LINE] = mk_line(4'b0011, 4'd1, DW_DFLD'(32'h5));
    step(0, 1, v, 1);
    step(0, 0, '0, 1);

    // Reset mid-drain with in_valid present during reset
    v = '0;
    for (int l = 0; l < 4; l++)
      v[(2*l)*DW_LINE +: DW_LINE] = mk_line(4'b1000, 4'(l), DW_DFLD'(32'h300 + l));
    step(0, 1, v, 1);
    step(0, 0, '0, 1);
    step(1, 1, v, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      int dens;
      dens = (k % 50 < 5) ? 0 : int'($urandom_range(10, 90));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 60), rand_vec(dens),
           ($urandom_range(0, 99) < 70));
    end
    for (int k = 0; k < 12; k++) step(0, 0, '0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
